usb_tx_pkt: RTL and testbench

Second-generation USB transmit packetizer.
- Buffers payload bytes in an internal FIFO and accepts packet commands (PID, data/handshake, zero-length).
- Emits a complete byte stream to the SIE: SYNC, PID, payload, CRC16 lo/hi.
- Honours SIE backpressure and enforces an inter-packet gap.
- A data packet starts only when its full payload is buffered, so it can never underrun mid-packet.

---
 rtl/usb_tx_pkt.sv | 261 ++++++++++++++++++++++++++
 tb/tb_usb_tx_pkt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_pkt.sv
`timescale 1ns/1ps
// usb_tx_pkt: USB transmit packetizer.
// Buffers payload bytes with a per-entry "last" flag and frames each commanded
// packet as SYNC, PID, payload, CRC16 lo/hi to the SIE, then holds an
// inter-packet gap. A data packet is only started once its whole payload is
// buffered.
// Optional build macro: USB_TX_PKT_STATS_EN adds the stat_pkts/stat_bytes counters.
module usb_tx_pkt #(
  parameter int unsigned AW        = 6,
  parameter int unsigned IPG       = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic [7:0] in_d,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [3:0] pkt_pid,
  input  logic       pkt_has_data,
  input  logic       pkt_zlp,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  output logic [7:0] sie_d,
  output logic       sie_dv,
  input  logic       sie_ready,
  output logic       busy
`ifdef USB_TX_PKT_STATS_EN
  ,
  output logic [15:0] stat_pkts,
  output logic [23:0] stat_bytes
`endif
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GAP
  } state_t;

  state_t state, state_nxt;

  // FIFO storage: {last, byte}
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]   fifo_cnt, fifo_cnt_nxt;
  logic [AW:0]   pkt_cnt;

  // latched command and packet context
  logic [3:0]  pid_q, pid_nxt;
  logic        data_q, data_nxt;
  logic        zlp_q, zlp_nxt;
  logic [15:0] crc_q, crc_nxt, crc_upd;
  logic        cur_last, cur_last_nxt;
  logic [3:0]  gap_cnt, gap_nxt;
  logic [7:0]  sie_d_nxt;
  logic        sie_dv_nxt;

  logic        wr_en, rd_en, handoff, accept;
  logic [8:0]  head, head_next;

  // One byte of USB CRC16 (reflected poly 0xA001), LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  d);
    logic [15:0] r;
    r = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign handoff    = sie_dv & sie_ready;
  assign wr_en      = in_valid & in_ready;
  assign rd_en      = (state == ST_DATA) & handoff;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];
  assign crc_upd    = crc16_byte(crc_q, sie_d);
  assign busy       = (state != ST_IDLE);

  // Command acceptance; qualified by pkt_valid so the output idles low
  // whenever no command is being offered.
  always_comb begin
    pkt_ready = (state == ST_IDLE) & pkt_valid &
                (~pkt_has_data | pkt_zlp | (pkt_cnt != '0));
  end

  assign accept = pkt_ready;

  // Occupancy bookkeeping for the FIFO
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({wr_en, rd_en})
      2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
      2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // FIFO data array write
  always_ff @(posedge c) begin
    if (wr_en) mem[wr_ptr] <= {in_last, in_d};
  end

  // FIFO pointers, count, registered ready and complete-packet counter
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      in_ready <= 1'b1;
      pkt_cnt  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr_inc;
      fifo_cnt <= fifo_cnt_nxt;
      in_ready <= (fifo_cnt_nxt != (AW+1)'(DEPTH));
      case ({wr_en & in_last, rd_en & cur_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the next values of the registered SIE outputs.
  // sie_d is loaded one step ahead: in ST_DATA the byte after the current
  // head is fetched on the same handoff that pops the head.
  always_comb begin
    state_nxt    = state;
    sie_d_nxt    = sie_d;
    sie_dv_nxt   = sie_dv;
    cur_last_nxt = cur_last;
    crc_nxt      = crc_q;
    gap_nxt      = gap_cnt;
    pid_nxt      = pid_q;
    data_nxt     = data_q;
    zlp_nxt      = zlp_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt  = ST_SYNC;
          sie_d_nxt  = SYNC_BYTE;
          sie_dv_nxt = 1'b1;
          pid_nxt    = pkt_pid;
          data_nxt   = pkt_has_data;
          zlp_nxt    = pkt_has_data & pkt_zlp;
          crc_nxt    = 16'hFFFF;
        end
      end
      ST_SYNC: begin
        if (handoff) begin
          state_nxt = ST_PID;
          sie_d_nxt = {~pid_q, pid_q};
        end
      end
      ST_PID: begin
        if (handoff) begin
          if (!data_q) begin
            state_nxt  = ST_GAP;
            sie_d_nxt  = '0;
            sie_dv_nxt = 1'b0;
            gap_nxt    = '0;
          end else if (zlp_q) begin
            state_nxt = ST_CRC_LO;
            sie_d_nxt = ~crc_q[7:0];
          end else begin
            state_nxt    = ST_DATA;
            sie_d_nxt    = head[7:0];
            cur_last_nxt = head[8];
          end
        end
      end
      ST_DATA: begin
        if (handoff) begin
          crc_nxt = crc_upd;
          if (cur_last) begin
            state_nxt = ST_CRC_LO;
            sie_d_nxt = ~crc_upd[7:0];
          end else begin
            sie_d_nxt    = head_next[7:0];
            cur_last_nxt = head_next[8];
          end
        end
      end
      ST_CRC_LO: begin
        if (handoff) begin
          state_nxt = ST_CRC_HI;
          sie_d_nxt = ~crc_q[15:8];
        end
      end
      ST_CRC_HI: begin
        if (handoff) begin
          state_nxt  = ST_GAP;
          sie_d_nxt  = '0;
          sie_dv_nxt = 1'b0;
          gap_nxt    = '0;
        end
      end
      ST_GAP: begin
        gap_nxt = gap_cnt + 1'b1;
        if (gap_cnt == 4'(IPG - 1)) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt  = ST_IDLE;
        sie_dv_nxt = 1'b0;
      end
    endcase
  end

  // Registered SIE outputs and packet context
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sie_d    <= '0;
      sie_dv   <= 1'b0;
      cur_last <= 1'b0;
      crc_q    <= '0;
      gap_cnt  <= '0;
      pid_q    <= '0;
      data_q   <= 1'b0;
      zlp_q    <= 1'b0;
    end else begin
      sie_d    <= sie_d_nxt;
      sie_dv   <= sie_dv_nxt;
      cur_last <= cur_last_nxt;
      crc_q    <= crc_nxt;
      gap_cnt  <= gap_nxt;
      pid_q    <= pid_nxt;
      data_q   <= data_nxt;
      zlp_q    <= zlp_nxt;
    end
  end

`ifdef USB_TX_PKT_STATS_EN
  // Wrapping packet and byte statistics
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts  <= '0;
      stat_bytes <= '0;
    end else begin
      if (state_nxt == ST_GAP && state != ST_GAP) stat_pkts <= stat_pkts + 1'b1;
      if (handoff) stat_bytes <= stat_bytes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_pkt.sv
`timescale 1ns/1ps
// Directed bench for usb_tx_pkt: handshake, ZLP, data, gating, backpressure
// and mid-packet reset, with a software CRC16 model for data packets.
module tb_usb_tx_pkt;

  localparam int unsigned IPG_T = 2;

  logic       c;
  logic       rst_n;
  logic [7:0] in_d;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] pkt_pid;
  logic       pkt_has_data;
  logic       pkt_zlp;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] sie_d;
  logic       sie_dv;
  logic       sie_ready;
  logic       busy;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];

  usb_tx_pkt #(.AW(6), .IPG(IPG_T), .SYNC_BYTE(8'h80)) dut (
    .c(c), .rst_n(rst_n),
    .in_d(in_d), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .pkt_pid(pkt_pid), .pkt_has_data(pkt_has_data), .pkt_zlp(pkt_zlp),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .sie_d(sie_d), .sie_dv(sie_dv), .sie_ready(sie_ready), .busy(busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Software-style USB CRC16: xor byte in, then eight reflected shifts.
  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] crc;
    crc = 16'hFFFF;
    foreach (b[i]) begin
      crc = crc ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    return crc;
  endfunction

  // Expected stream for a data packet carrying pay_q.
  task automatic build_data_exp(input logic [3:0] pid);
    logic [15:0] crc;
    crc = crc_model(pay_q);
    exp_q = {};
    exp_q.push_back(8'h80);
    exp_q.push_back({~pid, pid});
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    exp_q.push_back(~crc[7:0]);
    exp_q.push_back(~crc[15:8]);
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    @(negedge c);
    in_d = d; in_valid = 1'b1; in_last = l;
    @(posedge c);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic write_pay();
    foreach (pay_q[i]) wr(pay_q[i], (i == pay_q.size() - 1));
  endtask

  task automatic send_cmd(input string tag, input logic [3:0] pid, input logic hd, input logic z);
    bit ok;
    ok = 1'b0;
    @(negedge c);
    pkt_pid = pid; pkt_has_data = hd; pkt_zlp = z; pkt_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (pkt_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge c);
    end
    chk($sformatf("%s_accept", tag), 32'(ok), 1);
    if (ok) begin
      @(posedge c);
      #1;
      pkt_valid = 1'b0;
      chk($sformatf("%s_sync_dv", tag), 32'(sie_dv), 1);
    end else begin
      pkt_valid = 1'b0;
    end
  endtask

  // Consume n bytes; duty is the percent chance of sie_ready per cycle.
  task automatic expect_stream(input string tag, input int unsigned n,
                               input int unsigned duty, input bit nogap);
    int unsigned idx, gaps;
    bit held, started;
    logic [7:0] held_d;
    idx = 0; gaps = 0; held = 1'b0; started = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 4000 && idx < n; cyc++) begin
      @(negedge c);
      sie_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      #1;
      if (held) begin
        chk($sformatf("%s_hold_dv", tag), 32'(sie_dv), 1);
        chk($sformatf("%s_hold_d", tag), 32'(sie_d), 32'(held_d));
      end
      if (sie_dv === 1'b1) begin
        started = 1'b1;
        if (sie_ready) begin
          chk($sformatf("%s_b%0d", tag, idx), 32'(sie_d), 32'(exp_q[idx]));
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_d = sie_d;
        end
      end else if (started) begin
        gaps++;
      end
    end
    chk($sformatf("%s_count", tag), idx, n);
    if (nogap) chk($sformatf("%s_nogap", tag), gaps, 0);
  endtask

  task automatic check_gap(input string tag);
    for (int i = 0; i < IPG_T; i++) begin
      @(negedge c);
      #1;
      chk($sformatf("%s_gap_dv%0d", tag, i), 32'(sie_dv), 0);
      chk($sformatf("%s_gap_busy%0d", tag, i), 32'(busy), 1);
    end
    @(negedge c);
    #1;
    chk($sformatf("%s_idle_busy", tag), 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_d = '0; in_valid = 1'b0; in_last = 1'b0;
    pkt_pid = '0; pkt_has_data = 1'b0; pkt_zlp = 1'b0; pkt_valid = 1'b0;
    sie_ready = 1'b0;

    // reset state
    repeat (2) @(negedge c);
    #1;
    chk("rst_sie_d", 32'(sie_d), 0);
    chk("rst_sie_dv", 32'(sie_dv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt_ready", 32'(pkt_ready), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge c);
    rst_n = 1'b1;
    sie_ready = 1'b1;

    // ACK handshake: 80 D2 then gap
    exp_q = {8'h80, 8'hD2};
    send_cmd("ack", 4'h2, 1'b0, 1'b0);
    expect_stream("ack", 2, 100, 1'b1);
    check_gap("ack");

    // DATA0 zero-length packet: CRC of nothing inverts to 00 00
    exp_q = {8'h80, 8'hC3, 8'h00, 8'h00};
    send_cmd("zlp", 4'h3, 1'b1, 1'b1);
    expect_stream("zlp", 4, 100, 1'b1);
    check_gap("zlp");

    // DATA1 with payload 00 01 02 03
    pay_q = {8'h00, 8'h01, 8'h02, 8'h03};
    write_pay();
    build_data_exp(4'hB);
    send_cmd("data", 4'hB, 1'b1, 1'b0);
    expect_stream("data", 8, 100, 1'b1);
    check_gap("data");

    // gating: no complete packet buffered, command must wait for in_last
    pay_q = {8'hA5, 8'h5A, 8'hFF};
    build_data_exp(4'h3);
    wr(8'hA5, 1'b0);
    wr(8'h5A, 1'b0);
    @(negedge c);
    pkt_pid = 4'h3; pkt_has_data = 1'b1; pkt_zlp = 1'b0; pkt_valid = 1'b1;
    #1;
    chk("gate_wait0", 32'(pkt_ready), 0);
    @(negedge c);
    #1;
    chk("gate_wait1", 32'(pkt_ready), 0);
    wr(8'hFF, 1'b1);
    chk("gate_ready", 32'(pkt_ready), 1);
    @(posedge c);
    #1;
    pkt_valid = 1'b0;
    chk("gate_sync_dv", 32'(sie_dv), 1);
    chk("gate_sync_d", 32'(sie_d), 32'h80);
    expect_stream("gate", 7, 100, 1'b1);
    check_gap("gate");

    // 64-byte packet fills the FIFO; full sie_ready reference run
    pay_q = {};
    for (int i = 0; i < 64; i++) pay_q.push_back(8'((i * 37 + 11) & 8'hFF));
    write_pay();
    chk("full_in_ready", 32'(in_ready), 0);
    build_data_exp(4'hB);
    send_cmd("big", 4'hB, 1'b1, 1'b0);
    expect_stream("big", 68, 100, 1'b1);
    check_gap("big");
    chk("drain_in_ready", 32'(in_ready), 1);

    // same packet under 30% sie_ready duty
    write_pay();
    send_cmd("bp", 4'hB, 1'b1, 1'b0);
    expect_stream("bp", 68, 30, 1'b0);
    sie_ready = 1'b1;
    check_gap("bp");

    // reset in the middle of a data packet
    pay_q = {};
    for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h30 + i));
    write_pay();
    build_data_exp(4'h3);
    send_cmd("mid", 4'h3, 1'b1, 1'b0);
    expect_stream("mid", 4, 100, 1'b0);
    @(negedge c);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", 32'(sie_dv), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge c);
    rst_n = 1'b1;
    pkt_pid = 4'h3; pkt_has_data = 1'b1; pkt_zlp = 1'b0; pkt_valid = 1'b1;
    #1;
    chk("mid_rst_no_pkt", 32'(pkt_ready), 0);
    pkt_valid = 1'b0;

    exp_q = {8'h80, 8'hD2};
    send_cmd("ack2", 4'h2, 1'b0, 1'b0);
    expect_stream("ack2", 2, 100, 1'b1);
    check_gap("ack2");

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
